// File: rtl/clk_gen_monitor.sv
// Clock-generator lock monitor: synchronizes and debounces the generator's lock
// pin after the PLD enables the clocks, enforces a lock timeout and latches faults.
module clk_gen_monitor #(
  parameter int LOCK_TIMEOUT    = 1000,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 16
) (
  input  logic       iClk,
  input  logic       iRst_n,
  input  logic       iClksOeN,
  input  logic       iBclk5OeN,
  input  logic       iClkGenLock,
  input  logic       iFaultClr,
  output logic       oClksGood,
  output logic       oBclk5Good,
  output logic       oClkFault,
  output logic [1:0] oFaultCode,
  output logic [2:0] oState
);

  localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] TMR_MAX  = {CNT_W{1'b1}};
  localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);

  localparam logic [1:0] CODE_NONE = 2'b00;
  localparam logic [1:0] CODE_TMO  = 2'b01;
  localparam logic [1:0] CODE_LOST = 2'b10;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_LOCK = 3'd1,
    DEBOUNCE  = 3'd2,
    GOOD      = 3'd3,
    FAULT     = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       code_d;
  logic             lock_m, lock_s;
  logic [CNT_W-1:0] timer;
  logic [DB_W-1:0]  dbcnt;
  logic             oe, tmo, db_done;

  assign oe      = !iClksOeN;
  assign tmo     = (timer == TMO_LAST);
  assign db_done = (dbcnt == DB_LAST);

  // lock pin is asynchronous to iClk; only lock_s is used downstream
  always_ff @(posedge iClk) begin
    if (!iRst_n) begin
      lock_m <= 1'b0;
      lock_s <= 1'b0;
    end else begin
      lock_m <= iClkGenLock;
      lock_s <= lock_m;
    end
  end

  // Timer runs across WAIT_LOCK/DEBOUNCE bounces so a flapping lock still times out
  always_ff @(posedge iClk) begin
    if (!iRst_n || state_q == IDLE)
      timer <= '0;
    else if ((state_q == WAIT_LOCK || state_q == DEBOUNCE) && timer != TMR_MAX)
      timer <= timer + CNT_W'(1);
  end

  always_ff @(posedge iClk) begin
    if (!iRst_n || state_q != DEBOUNCE)
      dbcnt <= '0;
    else if (lock_s && !db_done)
      dbcnt <= dbcnt + DB_W'(1);
  end

  always_comb begin
    state_d = state_q;
    code_d  = oFaultCode;
    case (state_q)
      IDLE: begin
        if (oe) state_d = WAIT_LOCK;
      end
      WAIT_LOCK: begin
        if (!oe)
          state_d = IDLE;
        else if (lock_s)
          state_d = DEBOUNCE;
        else if (tmo) begin
          state_d = FAULT;
          code_d  = CODE_TMO;
        end
      end
      DEBOUNCE: begin
        if (!oe)
          state_d = IDLE;
        else if (!lock_s)
          state_d = WAIT_LOCK;
        else if (db_done)
          state_d = GOOD;
        else if (tmo) begin
          state_d = FAULT;
          code_d  = CODE_TMO;
        end
      end
      GOOD: begin
        if (!oe)
          state_d = IDLE;
        else if (!lock_s) begin
          state_d = FAULT;
          code_d  = CODE_LOST;
        end
      end
      FAULT: begin
        if (iFaultClr && !oe) begin
          state_d = IDLE;
          code_d  = CODE_NONE;
        end
      end
      default: begin
        state_d = IDLE;
        code_d  = CODE_NONE;
      end
    endcase
  end

  // Outputs load from the next-state decode so they move with the state
  always_ff @(posedge iClk) begin
    if (!iRst_n) begin
      state_q    <= IDLE;
      oClksGood  <= 1'b0;
      oBclk5Good <= 1'b0;
      oClkFault  <= 1'b0;
      oFaultCode <= CODE_NONE;
    end else begin
      state_q    <= state_d;
      oClksGood  <= (state_d == GOOD);
      oBclk5Good <= (state_d == GOOD) && !iBclk5OeN;
      oClkFault  <= (state_d == FAULT);
      oFaultCode <= code_d;
    end
  end

  assign oState = state_q;

endmodule
